immediate_generation_unit: RTL and testbench
============================================

Name: immediate_generation_unit

Overview:
Registered RV64I immediate generator for the datapath decode stage. It takes a 32-bit instruction and extracts and sign-extends its immediate to 64 bits according to the opcode format (I, S, B, U, J). The result feeds the ALU B-mux and the branch/jump target adder one clock later.

Parameters:
XLEN, 64, output immediate width. Sign extension always reaches bit XLEN-1.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  instruction qualifier; capture only when high
instruction  input  32  raw RISC-V instruction word
immediate  output  XLEN  signed, sign-extended immediate (registered)
out_valid  output  1  high one cycle after an accepted instruction

Behaviour:
- Reset, sampled on the rising clk edge while reset=1:
  - immediate=0, out_valid=0.
  - Reset has priority over in_valid, including mid-stream.
- Latency is exactly 1 cycle. On a rising edge with in_valid=1:
  - immediate <= decoded value of instruction.
  - out_valid <= 1.
- On a rising edge with in_valid=0:
  - immediate holds its previous value.
  - out_valid <= 0.
- Format selection uses opcode = instruction[6:0]:
  - I-type: 0010011 (OP-IMM), 0011011 (OP-IMM-32), 0000011 (LOAD), 1100111 (JALR).
    - imm = sext(inst[31:20]).
    - Shifts use the same full sign-extended 12-bit field; the ALU masks the shamt.
  - S-type: 0100011 (STORE).
    - imm = sext({inst[31:25], inst[11:7]}).
  - B-type: 1100011 (BRANCH).
    - imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
    - Bit 0 is always 0; the value is a byte offset.
  - U-type: 0110111 (LUI), 0010111 (AUIPC).
    - imm = sext({inst[31:12], 12'b0}), so bits 63:32 copy inst[31].
  - J-type: 1101111 (JAL).
    - imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Any other opcode (R-type, SYSTEM, FENCE, unknown): imm = 0.
- Sign bit is always inst[31] for every format.
- Decode is purely combinational ahead of the output register. There are no other state elements.
- Back-to-back valid instructions are decoded one per cycle with no stalls.

Optional Feature:
Macro IMM_ILLEGAL_DETECT_EN.
- When defined:
  - Adds output port illegal_opcode, 1 bit, registered alongside immediate.
  - It is set to 1 when an accepted instruction has opcode[1:0]!=2'b11, or has an opcode outside the I/S/B/U/J list and outside 0110011, 0111011, 1110011 and 0001111.
  - Reset value is 0. It holds when in_valid=0.
- When undefined:
  - The port does not exist.
  - Unknown opcodes simply produce imm=0.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1 and an addi instruction -> immediate=0, out_valid=0 throughout. One cycle after deassertion -> correct value, out_valid=1.
- I-type:
  - addi 0x00200013 -> 2; addi 0xFFE00013 -> -2.
  - lw 0x00402003 -> 4; lw 0xFFC02003 -> -4.
  - jalr 0x80000067 -> -2048 (0xFFFF_FFFF_FFFF_F800).
- S-type: sw 0x00002423 -> 8; sw 0xFE002C23 -> -8.
- B-type:
  - 0x00000863 -> 16; 0xFE0008E3 -> -16.
  - 0x80000063 -> -4096.
  - Check bit 0 is always 0.
- U/J and other:
  - lui 0x800000B7 -> 0xFFFF_FFFF_8000_0000; auipc 0x12345017 -> 0x0000_0000_1234_5000.
  - jal 0x0080006F -> 8; jal 0x8000006F -> -1048576.
  - add 0x00B50533 -> 0.
- Handshake:
  - Stream 3 valid instructions back-to-back -> results appear in order, one per cycle, each 1 cycle late.
  - Drop in_valid for 2 cycles -> immediate holds last value, out_valid=0.
  - Assert reset mid-stream -> outputs clear on the next edge.

Source files
------------

// File: rtl/immediate_generation_unit.sv
// Registered RV64I immediate generator: decodes I/S/B/U/J immediates, sign-extended to XLEN.
// Optional macro IMM_ILLEGAL_DETECT_EN adds a registered illegal_opcode flag.
module immediate_generation_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] immediate,
    output logic            out_valid
`ifdef IMM_ILLEGAL_DETECT_EN
    ,
    output logic            illegal_opcode
`endif
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_32  = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Every format takes its sign from inst[31]; non-immediate opcodes yield zero.
    function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] inst);
        logic [XLEN-1:0] imm;
        imm = {XLEN{1'b0}};
        case (inst[6:0])
            OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR:
                imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
            OP_JAL:
                imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = {XLEN{1'b0}};
        endcase
        return imm;
    endfunction

`ifdef IMM_ILLEGAL_DETECT_EN
    function automatic logic is_illegal(input logic [6:0] op);
        logic ill;
        ill = 1'b0;
        if (op[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (op)
                OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH,
                OP_LUI, OP_AUIPC, OP_JAL, OP_OP, OP_OP_32, OP_SYSTEM, OP_FENCE:
                    ill = 1'b0;
                default:
                    ill = 1'b1;
            endcase
        end
        return ill;
    endfunction
`endif

    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] r_imm;
    logic            r_valid;

    assign w_imm = decode_imm(instruction);

    // Output register: reset wins, capture on in_valid, otherwise hold the immediate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_imm   <= {XLEN{1'b0}};
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_imm   <= w_imm;
            r_valid <= 1'b1;
        end else begin
            r_imm   <= r_imm;
            r_valid <= 1'b0;
        end
    end

    assign immediate = r_imm;
    assign out_valid = r_valid;

`ifdef IMM_ILLEGAL_DETECT_EN
    logic w_illegal;
    logic r_illegal;

    assign w_illegal = is_illegal(instruction[6:0]);

    // Illegal-opcode flag shares the capture/hold behaviour of the immediate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (in_valid) begin
            r_illegal <= w_illegal;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    assign illegal_opcode = r_illegal;
`endif

endmodule

// File: tb/tb_immediate_generation_unit.sv
// Directed self-checking bench for immediate_generation_unit (default XLEN=64).
// Covers IMM_ILLEGAL_DETECT_EN when that macro is defined for the build.
module tb_immediate_generation_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction;
    logic [63:0] immediate;
    logic        out_valid;
`ifdef IMM_ILLEGAL_DETECT_EN
    logic        illegal_opcode;
`endif

    int total;
    int bad;

    immediate_generation_unit #(.XLEN(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .instruction (instruction),
        .immediate   (immediate),
        .out_valid   (out_valid)
`ifdef IMM_ILLEGAL_DETECT_EN
        ,
        .illegal_opcode (illegal_opcode)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic v, input logic [31:0] ins);
        @(negedge clk);
        reset       = rst;
        in_valid    = v;
        instruction = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [63:0] imm, input logic ov);
        chk({tag, "_imm"}, immediate, imm);
        chk({tag, "_ov"}, {63'd0, out_valid}, {63'd0, ov});
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h0020_0013;

        // Reset held two cycles with a valid addi presented
        step(1'b1, 1'b1, 32'h0020_0013);
        expect_out("rst0", 64'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0020_0013);
        expect_out("rst1", 64'h0, 1'b0);
`ifdef IMM_ILLEGAL_DETECT_EN
        chk("rst_ill", {63'd0, illegal_opcode}, 64'd0);
`endif
        step(1'b0, 1'b1, 32'h0020_0013);
        expect_out("addi_p2", 64'h0000_0000_0000_0002, 1'b1);

        // I-type
        step(1'b0, 1'b1, 32'hFFE0_0013);
        expect_out("addi_m2", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        step(1'b0, 1'b1, 32'h0040_2003);
        expect_out("lw_p4", 64'h0000_0000_0000_0004, 1'b1);
        step(1'b0, 1'b1, 32'hFFC0_2003);
        expect_out("lw_m4", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        step(1'b0, 1'b1, 32'h8000_0067);
        expect_out("jalr_m2048", 64'hFFFF_FFFF_FFFF_F800, 1'b1);
        step(1'b0, 1'b1, 32'h8000_001B);
        expect_out("addiw_m2048", 64'hFFFF_FFFF_FFFF_F800, 1'b1);

        // S-type
        step(1'b0, 1'b1, 32'h0000_2423);
        expect_out("sw_p8", 64'h0000_0000_0000_0008, 1'b1);
        step(1'b0, 1'b1, 32'hFE00_2C23);
        expect_out("sw_m8", 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);

        // B-type
        step(1'b0, 1'b1, 32'h0000_0863);
        expect_out("br_p16", 64'h0000_0000_0000_0010, 1'b1);
        step(1'b0, 1'b1, 32'hFE00_08E3);
        expect_out("br_m16", 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);
        step(1'b0, 1'b1, 32'h8000_0063);
        expect_out("br_m4096", 64'hFFFF_FFFF_FFFF_F000, 1'b1);
        step(1'b0, 1'b1, 32'hFE00_0FE3);
        expect_out("br_m2", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        chk("br_bit0", {63'd0, immediate[0]}, 64'd0);

        // U/J and non-immediate opcodes
        step(1'b0, 1'b1, 32'h8000_00B7);
        expect_out("lui_neg", 64'hFFFF_FFFF_8000_0000, 1'b1);
        step(1'b0, 1'b1, 32'h1234_5017);
        expect_out("auipc", 64'h0000_0000_1234_5000, 1'b1);
        step(1'b0, 1'b1, 32'h0080_006F);
        expect_out("jal_p8", 64'h0000_0000_0000_0008, 1'b1);
        step(1'b0, 1'b1, 32'h8000_006F);
        expect_out("jal_m1m", 64'hFFFF_FFFF_FFF0_0000, 1'b1);
        step(1'b0, 1'b1, 32'h00B5_0533);
        expect_out("add_zero", 64'h0, 1'b1);
`ifdef IMM_ILLEGAL_DETECT_EN
        chk("add_ill", {63'd0, illegal_opcode}, 64'd0);
`endif
        step(1'b0, 1'b1, 32'h8000_000F);
        expect_out("fence_zero", 64'h0, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FF7B);
        expect_out("unknown_zero", 64'h0, 1'b1);
`ifdef IMM_ILLEGAL_DETECT_EN
        chk("unk_ill", {63'd0, illegal_opcode}, 64'd1);
        step(1'b0, 1'b1, 32'hFFFF_FF10);
        chk("lowbits_ill", {63'd0, illegal_opcode}, 64'd1);
        step(1'b0, 1'b0, 32'h0020_0013);
        chk("hold_ill", {63'd0, illegal_opcode}, 64'd1);
`endif

        // Back-to-back stream, then two idle cycles holding the last value
        step(1'b0, 1'b1, 32'h0020_0013);
        expect_out("s0", 64'h0000_0000_0000_0002, 1'b1);
        step(1'b0, 1'b1, 32'h0000_2423);
        expect_out("s1", 64'h0000_0000_0000_0008, 1'b1);
        step(1'b0, 1'b1, 32'h8000_00B7);
        expect_out("s2", 64'hFFFF_FFFF_8000_0000, 1'b1);
        step(1'b0, 1'b0, 32'h0020_0013);
        expect_out("idle0", 64'hFFFF_FFFF_8000_0000, 1'b0);
        step(1'b0, 1'b0, 32'h0000_0863);
        expect_out("idle1", 64'hFFFF_FFFF_8000_0000, 1'b0);

        // Reset mid-stream clears on the next edge despite in_valid
        step(1'b0, 1'b1, 32'hFFE0_0013);
        expect_out("pre_rst", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        step(1'b1, 1'b1, 32'h0040_2003);
        expect_out("mid_rst", 64'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0040_2003);
        expect_out("post_rst", 64'h0000_0000_0000_0004, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
